// File: rtl/next_pc_unit.sv
// Next-PC sequencer with a single delay slot, trap redirect and stall hold.
// Optional delay-slot annulment is compiled in with NPC_ANNUL_EN.
//
// state | meaning
// BOOT  | first cycle after reset, loads RESET_PC
// RUN   | sequential fetch, may accept a taken branch
// SLOT  | delay-slot instruction is at PC, npc holds the branch target
module next_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        branch_annul,
  input  logic        trap_req,
  output logic [31:0] pc_next,
  output logic        le_pc,
  output logic [31:0] npc,
  output logic        fetch_valid,
  output logic        in_delay_slot,
  output logic        err_branch_in_slot
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    SLOT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] npc_q, npc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        in_delay_slot_q, in_delay_slot_d;
  logic        err_q, err_d;
  logic        slot_fetch_valid;

  // Target low bits are forced to zero; annul is only consumed when enabled.
  logic unused_inputs;
  assign unused_inputs = ^{branch_target[1:0], branch_annul};

`ifdef NPC_ANNUL_EN
  assign slot_fetch_valid = ~branch_annul;
`else
  assign slot_fetch_valid = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= BOOT;
      npc_q           <= RESET_PC + 32'd4;
      fetch_valid_q   <= 1'b0;
      in_delay_slot_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      npc_q           <= npc_d;
      fetch_valid_q   <= fetch_valid_d;
      in_delay_slot_q <= in_delay_slot_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    npc_d           = npc_q;
    fetch_valid_d   = fetch_valid_q;
    in_delay_slot_d = in_delay_slot_q;
    err_d           = 1'b0;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN, SLOT: begin
        if (trap_req) begin
          // Trap wins over stall and drops any pending branch target.
          state_d         = RUN;
          npc_d           = TRAP_VECTOR + 32'd4;
          fetch_valid_d   = 1'b1;
          in_delay_slot_d = 1'b0;
        end else if (!stall) begin
          if (state_q == SLOT) begin
            state_d         = RUN;
            npc_d           = npc_q + 32'd4;
            fetch_valid_d   = 1'b1;
            in_delay_slot_d = 1'b0;
            err_d           = branch_taken;
          end else if (branch_taken) begin
            state_d         = SLOT;
            npc_d           = {branch_target[31:2], 2'b00};
            fetch_valid_d   = slot_fetch_valid;
            in_delay_slot_d = 1'b1;
          end else begin
            npc_d         = npc_q + 32'd4;
            fetch_valid_d = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    le_pc   = 1'b0;
    pc_next = npc_q;
    if (reset) begin
      case (state_q)
        BOOT: begin
          le_pc   = 1'b1;
          pc_next = RESET_PC;
        end
        RUN, SLOT: begin
          if (trap_req) begin
            le_pc   = 1'b1;
            pc_next = TRAP_VECTOR;
          end else begin
            le_pc = ~stall;
          end
        end
        default: le_pc = 1'b0;
      endcase
    end
  end

  assign npc                = npc_q;
  assign fetch_valid        = fetch_valid_q;
  assign in_delay_slot      = in_delay_slot_q;
  assign err_branch_in_slot = err_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: directed scenarios then random traffic,
// each cycle checked against a fetch-sequence reference model.
module tb_next_pc_unit;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        branch_annul = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] pc_next, npc;
  logic        le_pc, fetch_valid, in_delay_slot, err_branch_in_slot;

  int errors = 0;
  int checks = 0;

  next_pc_unit #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .branch_annul(branch_annul), .trap_req(trap_req),
    .pc_next(pc_next), .le_pc(le_pc), .npc(npc), .fetch_valid(fetch_valid),
    .in_delay_slot(in_delay_slot), .err_branch_in_slot(err_branch_in_slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_regs;
    logic        le;
    logic [31:0] pcn;
    logic [31:0] npc;
    logic        fv;
    logic        ids;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: what has been fetched and what the next fetch will be.
  logic        m_known = 1'b0;
  logic        m_booting = 1'b1;
  logic        m_slot = 1'b0;
  logic [31:0] m_npc = '0;
  logic        m_fv = 1'b0;
  logic        m_err = 1'b0;

`ifdef NPC_ANNUL_EN
  localparam bit ANNUL_EN = 1'b1;
`else
  localparam bit ANNUL_EN = 1'b0;
`endif

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input logic a, input logic tr);
    exp_t        e;
    logic        n_booting, n_slot, n_fv, n_err;
    logic [31:0] n_npc;
    @(negedge clk);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    branch_annul = a; trap_req = tr;
    e.chk_regs = m_known; e.npc = m_npc; e.fv = m_fv; e.ids = m_slot; e.err = m_err;
    e.le = 1'b0; e.pcn = '0;
    n_booting = m_booting; n_slot = m_slot; n_npc = m_npc; n_fv = m_fv; n_err = 1'b0;
    if (!r) begin
      n_booting = 1'b1; n_slot = 1'b0; n_npc = RESET_PC + 4; n_fv = 1'b0;
    end else if (m_booting) begin
      e.le = 1'b1; e.pcn = RESET_PC; n_booting = 1'b0; n_fv = 1'b1;
    end else if (tr) begin
      e.le = 1'b1; e.pcn = TRAP_VECTOR; n_npc = TRAP_VECTOR + 4; n_slot = 1'b0; n_fv = 1'b1;
    end else if (!s) begin
      e.le = 1'b1; e.pcn = m_npc;
      if (m_slot) begin
        n_err = b; n_npc = m_npc + 4; n_slot = 1'b0; n_fv = 1'b1;
      end else if (b) begin
        n_npc = t & 32'hFFFF_FFFC; n_slot = 1'b1; n_fv = ANNUL_EN ? !a : 1'b1;
      end else begin
        n_npc = m_npc + 4; n_fv = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) m_known = 1'b1;
    m_booting = n_booting; m_slot = n_slot; m_npc = n_npc; m_fv = n_fv; m_err = n_err;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("le_pc", {31'b0, le_pc}, {31'b0, e.le});
        if (e.le) cmp("pc_next", pc_next, e.pcn);
        if (e.chk_regs) begin
          cmp("npc", npc, e.npc);
          cmp("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
          cmp("in_delay_slot", {31'b0, in_delay_slot}, {31'b0, e.ids});
          cmp("err_branch_in_slot", {31'b0, err_branch_in_slot}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin : driver
    // Reset two cycles, boot, sequential fetch to npc=0x10
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Branch to 0x203 (aligned 0x200), stall 3 cycles in SLOT
    step(1, 0, 1, 32'h203, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Branch while stalled is ignored, then branch-in-slot error
    step(1, 1, 1, 32'h400, 0, 0);
    step(1, 0, 1, 32'h400, 0, 0);
    step(1, 0, 1, 32'h800, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Trap in SLOT with stall high
    step(1, 0, 1, 32'h600, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    // Trap in BOOT ignored; reset mid-stall in SLOT
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 32'h300, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Wrap at top of address space
    step(1, 0, 1, 32'hFFFF_FFF8, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Annulled branch: slot fetch invalid only when annul is built in
    step(1, 0, 1, 32'h1000, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 30), $urandom, $urandom_range(0, 1),
           ($urandom_range(0, 99) < 5));
    end
    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0080: fetch address on trap.
REQ-003 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rise).
REQ-005 SHALL have port stall  in  1  hold fetch (hazard or memory wait).
REQ-006 SHALL have port branch_taken  in  1  resolved taken branch/jump, valid one cycle.
REQ-007 SHALL have port branch_target  in  32  branch destination.
REQ-008 SHALL have port branch_annul  in  1  squash the delay-slot instruction (used only under REQ-031).
REQ-009 SHALL have port trap_req  in  1  redirect to TRAP_VECTOR.
REQ-010 SHALL have port pc_next  out  32  combinational value driven into the PC register pc_in.
REQ-011 SHALL have port le_pc  out  1  combinational load enable for the PC register.
REQ-012 SHALL have port npc  out  32  registered nPC.
REQ-013 SHALL have port fetch_valid  out  1  registered; instruction at the current PC is valid.
REQ-014 SHALL have port in_delay_slot  out  1  registered; current PC is a delay slot.
REQ-015 SHALL have port err_branch_in_slot  out  1  registered one-cycle pulse.

Function
REQ-016 SHALL implement states BOOT, RUN and SLOT; "advance" means le_pc=1.
REQ-017 BOOT SHALL last one cycle: pc_next=RESET_PC, le_pc=1, npc held, next state RUN, fetch_valid<=1.
REQ-018 RUN, no event: le_pc=!stall; on advance pc_next=npc, npc<=npc+4.
REQ-019 RUN, branch_taken on advance: pc_next=npc (delay slot), npc<={branch_target[31:2],2'b00}, in_delay_slot<=1, next state SLOT.
REQ-020 SLOT on advance: pc_next=npc (target), npc<=npc+4, in_delay_slot<=0, next state RUN.
REQ-021 branch_taken in SLOT SHALL be ignored and SHALL pulse err_branch_in_slot for one cycle.
REQ-022 branch_taken while stall=1 SHALL be ignored; upstream holds it until an advance.
REQ-023 stall=1 SHALL hold npc, state, in_delay_slot and fetch_valid with le_pc=0.
REQ-024 trap_req SHALL have highest priority in RUN or SLOT, overriding stall: le_pc=1, pc_next=TRAP_VECTOR, npc<=TRAP_VECTOR+4, state RUN, in_delay_slot<=0, fetch_valid<=1; any pending target is dropped.
REQ-025 trap_req in BOOT SHALL be ignored.
REQ-026 npc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 fetch_valid SHALL be set to 1 on every advance, except as given in REQ-031.

Reset
REQ-028 While reset=0 at clk rise: state<=BOOT, npc<=RESET_PC+4, fetch_valid<=0, in_delay_slot<=0, err_branch_in_slot<=0.
REQ-029 While reset=0, le_pc SHALL be 0.
REQ-030 Reset mid-SLOT or mid-stall SHALL discard all pending state.

Configuration
REQ-031 With NPC_ANNUL_EN defined, a branch with branch_annul=1 on advance SHALL set fetch_valid<=0 for the delay slot, and fetch_valid SHALL return to 1 on the next advance.
REQ-032 Without NPC_ANNUL_EN, branch_annul SHALL be ignored and fetch_valid SHALL be set to 1 on every advance.

Verification
REQ-033 Reset low 2 cycles, release, RESET_PC=0 -> BOOT cycle pc_next=0 le_pc=1; then pc_next 4, 8, 12; fetch_valid 0 then 1.
REQ-034 npc=0x10, branch_taken target 0x203 -> pc_next 0x10 (in_delay_slot=1), then 0x200, then 0x204.
REQ-035 SLOT with stall high 3 cycles -> le_pc=0, npc=0x200 held for 3 cycles; then pc_next=0x200.
REQ-036 branch_taken asserted in SLOT -> err_branch_in_slot=1 for one cycle; second target unused.
REQ-037 trap_req in SLOT with stall=1 -> pc_next=0x80, le_pc=1, npc=0x84, in_delay_slot=0.
REQ-038 npc=0xFFFF_FFFC advance -> npc=0; with NPC_ANNUL_EN, annulled branch -> fetch_valid 0 for the slot, then 1.
